// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped branch target buffer with 2-bit counters
//
// Purpose: zero-latency fetch-stage next-PC prediction, trained by the resolved
// control-flow outcome from Execute, plus resolved/mispredict statistics.
//
// Ports:
//   clk          - sole clock, rising edge
//   resetn       - synchronous active-low reset
//   PCF          - fetch PC to predict from
//   predPCF      - predicted next PC (target on taken hit, else PCF+4)
//   predTakenF   - lookup hit with taken prediction
//   updValidE    - control-flow instruction resolved this cycle
//   updPCE       - PC of the resolved instruction
//   updTakenE    - resolved direction
//   updTargetE   - resolved target address
//   updMispredE  - resolved next PC differed from prediction
//   flushAll     - invalidate the whole table
//   branchCount  - saturating count of resolved control-flow instructions
//   mispredCount - saturating count of mispredicted ones
module btb_predictor #(
  parameter int XLEN       = 64,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 10
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] predPCF,
  output logic            predTakenF,
  input  logic            updValidE,
  input  logic [XLEN-1:0] updPCE,
  input  logic            updTakenE,
  input  logic [XLEN-1:0] updTargetE,
  input  logic            updMispredE,
  input  logic            flushAll,
  output logic [31:0]     branchCount,
  output logic [31:0]     mispredCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [31:0]         r_branch_count;
  logic [31:0]         r_mispred_count;

  logic [INDEX_BITS-1:0] w_look_idx;
  logic [TAG_BITS-1:0]   w_look_tag;
  logic                  w_look_hit;
  logic                  w_pred_taken;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_hit;
  logic                  w_unused_pc_bits;

  // Only the index and tag fields of the PCs take part in the lookup.
  assign w_unused_pc_bits = ^{PCF[XLEN-1:TAG_HI+1], PCF[1:0],
                              updPCE[XLEN-1:TAG_HI+1], updPCE[1:0]};

  assign w_look_idx = PCF[INDEX_BITS+1:2];
  assign w_look_tag = PCF[TAG_HI:TAG_LO];
  assign w_look_hit = r_valid[w_look_idx] && (r_tag[w_look_idx] == w_look_tag);

  // Gating with resetn keeps the prediction a pure function of PCF while the
  // table is being reset (it may hold garbage before the first reset edge).
  assign w_pred_taken = resetn && w_look_hit && r_ctr[w_look_idx][1];

  assign predTakenF = w_pred_taken;
  assign predPCF    = w_pred_taken ? r_target[w_look_idx] : PCF + XLEN'(4);

  assign w_upd_idx = updPCE[INDEX_BITS+1:2];
  assign w_upd_tag = updPCE[TAG_HI:TAG_LO];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  assign branchCount  = r_branch_count;
  assign mispredCount = r_mispred_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid         <= '0;
      r_branch_count  <= '0;
      r_mispred_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else begin
      // Statistics run regardless of flushAll.
      if (updValidE && (r_branch_count != 32'hFFFF_FFFF)) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (updValidE && updMispredE && (r_mispred_count != 32'hFFFF_FFFF)) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end

      if (flushAll) begin
        // Only valid bits are cleared; a same-cycle update is dropped.
        r_valid <= '0;
      end else if (updValidE) begin
        if (w_upd_hit) begin
          if (updTakenE) begin
            if (r_ctr[w_upd_idx] != 2'b11) begin
              r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
            end
            r_target[w_upd_idx] <= updTargetE;
          end else if (r_ctr[w_upd_idx] != 2'b00) begin
            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
          end
        end else if (updTakenE) begin
          // Allocate (or replace an aliasing entry) as weakly taken.
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= updTargetE;
          r_ctr[w_upd_idx]    <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - table-driven bench for btb_predictor
module tb_btb_predictor;

  logic        clk;
  logic        resetn;
  logic [63:0] PCF;
  logic [63:0] predPCF;
  logic        predTakenF;
  logic        updValidE;
  logic [63:0] updPCE;
  logic        updTakenE;
  logic [63:0] updTargetE;
  logic        updMispredE;
  logic        flushAll;
  logic [31:0] branchCount;
  logic [31:0] mispredCount;

  int n_checks = 0;
  int n_fail   = 0;

  btb_predictor #(.XLEN(64), .INDEX_BITS(4), .TAG_BITS(10)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .PCF          (PCF),
    .predPCF      (predPCF),
    .predTakenF   (predTakenF),
    .updValidE    (updValidE),
    .updPCE       (updPCE),
    .updTakenE    (updTakenE),
    .updTargetE   (updTargetE),
    .updMispredE  (updMispredE),
    .flushAll     (flushAll),
    .branchCount  (branchCount),
    .mispredCount (mispredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic [63:0] utgt;
    logic        um;
    logic [63:0] pcf;
    logic        et;
    logic [63:0] epred;
    logic [31:0] ebc;
    logic [31:0] emc;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(logic flush, logic uv, logic [63:0] upc, logic ut,
                              logic [63:0] utgt, logic um, logic [63:0] pcf,
                              logic et, logic [63:0] epred, logic [31:0] ebc,
                              logic [31:0] emc);
    vec_t v;
    v.flush = flush; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.um = um;
    v.pcf = pcf; v.et = et; v.epred = epred; v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic flush, input logic uv, input logic [63:0] upc,
                       input logic ut, input logic [63:0] utgt, input logic um,
                       input logic [63:0] pcf);
    flushAll = flush; updValidE = uv; updPCE = upc; updTakenE = ut;
    updTargetE = utgt; updMispredE = um; PCF = pcf;
  endtask

  initial begin
    // Lookups are checked before the edge that applies the same-row update,
    // so each row's expectation reflects the pre-update table.
    //            fl uv upc     ut utgt    um pcf      et epred   bc  mc
    vecs[0]  = mk(0, 0, 'h000, 0, 'h000, 0, 'h100,  0, 'h104,  0,  0);
    vecs[1]  = mk(0, 1, 'h100, 1, 'h200, 1, 'h100,  0, 'h104,  0,  0);
    vecs[2]  = mk(0, 0, 'h000, 0, 'h000, 0, 'h100,  1, 'h200,  1,  1);
    vecs[3]  = mk(0, 1, 'h100, 0, 'h000, 1, 'h100,  1, 'h200,  1,  1);
    vecs[4]  = mk(0, 1, 'h100, 0, 'h000, 0, 'h100,  0, 'h104,  2,  2);
    vecs[5]  = mk(0, 0, 'h000, 0, 'h000, 0, 'h100,  0, 'h104,  3,  2);
    vecs[6]  = mk(0, 1, 'h100, 1, 'h200, 1, 'h100,  0, 'h104,  3,  2);
    vecs[7]  = mk(0, 1, 'h100, 1, 'h200, 0, 'h100,  0, 'h104,  4,  3);
    vecs[8]  = mk(0, 1, 'h100, 1, 'h200, 0, 'h100,  1, 'h200,  5,  3);
    vecs[9]  = mk(0, 1, 'h100, 1, 'h200, 0, 'h100,  1, 'h200,  6,  3);
    vecs[10] = mk(0, 1, 'h100, 0, 'h000, 1, 'h100,  1, 'h200,  7,  3);
    vecs[11] = mk(0, 0, 'h000, 0, 'h000, 0, 'h100,  1, 'h200,  8,  4);
    vecs[12] = mk(0, 1, 'h100, 1, 'h300, 1, 'h100,  1, 'h200,  8,  4);
    vecs[13] = mk(0, 1, 'h100, 0, 'h999, 0, 'h100,  1, 'h300,  9,  5);
    vecs[14] = mk(0, 0, 'h000, 0, 'h000, 0, 'h100,  1, 'h300, 10,  5);
    vecs[15] = mk(0, 0, 'h000, 0, 'h000, 0, 'h140,  0, 'h144, 10,  5);
    vecs[16] = mk(0, 1, 'h140, 0, 'h000, 0, 'h100,  1, 'h300, 10,  5);
    vecs[17] = mk(0, 0, 'h000, 0, 'h000, 0, 'h100,  1, 'h300, 11,  5);
    vecs[18] = mk(0, 1, 'h140, 1, 'h400, 1, 'h140,  0, 'h144, 11,  5);
    vecs[19] = mk(0, 0, 'h000, 0, 'h000, 0, 'h140,  1, 'h400, 12,  6);
    vecs[20] = mk(0, 0, 'h000, 0, 'h000, 0, 'h100,  0, 'h104, 12,  6);
    vecs[21] = mk(0, 1, 'h104, 1, 'h500, 1, 'h104,  0, 'h108, 12,  6);
    vecs[22] = mk(0, 0, 'h000, 0, 'h000, 0, 'h104,  1, 'h500, 13,  7);
    vecs[23] = mk(1, 1, 'h108, 1, 'h600, 1, 'h140,  1, 'h400, 13,  7);
    vecs[24] = mk(0, 0, 'h000, 0, 'h000, 0, 'h140,  0, 'h144, 14,  8);
    vecs[25] = mk(0, 0, 'h000, 0, 'h000, 0, 'h104,  0, 'h108, 14,  8);
    vecs[26] = mk(0, 0, 'h000, 0, 'h000, 0, 'h108,  0, 'h10C, 14,  8);
    vecs[27] = mk(0, 0, 'h000, 0, 'h000, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 'h0, 14, 8);

    resetn = 1'b0;
    drive(0, 1, 'h100, 1, 'h200, 1, 'h100);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].flush, vecs[i].uv, vecs[i].upc, vecs[i].ut,
            vecs[i].utgt, vecs[i].um, vecs[i].pcf);
      #1;
      check($sformatf("v%0d taken", i), {63'd0, predTakenF}, {63'd0, vecs[i].et});
      check($sformatf("v%0d pred", i), predPCF, vecs[i].epred);
      check($sformatf("v%0d bcount", i), {32'd0, branchCount}, {32'd0, vecs[i].ebc});
      check($sformatf("v%0d mcount", i), {32'd0, mispredCount}, {32'd0, vecs[i].emc});
    end

    // Mid-run reset wins over a concurrent update and clears everything.
    @(negedge clk);
    drive(0, 1, 'h140, 1, 'h700, 0, 'h000);
    @(negedge clk);
    drive(0, 0, 'h000, 0, 'h000, 0, 'h140);
    #1;
    check("pre-reset hit", predPCF, 64'h700);
    @(negedge clk);
    resetn = 1'b0;
    drive(0, 1, 'h100, 1, 'h800, 1, 'h140);
    #1;
    check("in-reset taken", {63'd0, predTakenF}, 64'd0);
    check("in-reset pred", predPCF, 64'h144);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 0, 'h000, 0, 'h000, 0, 'h140);
    #1;
    check("post-reset 140 pred", predPCF, 64'h144);
    check("post-reset bcount", {32'd0, branchCount}, 64'd0);
    check("post-reset mcount", {32'd0, mispredCount}, 64'd0);
    PCF = 64'h100;
    #1;
    check("post-reset 100 pred", predPCF, 64'h104);

    // branchCount saturation from a preloaded near-max value.
    @(negedge clk);
    force dut.r_branch_count = 32'hFFFF_FFFE;
    drive(0, 1, 'h200, 0, 'h000, 1, 'h000);
    @(negedge clk);
    release dut.r_branch_count;
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 'h000, 0, 'h000, 0, 'h000);
    #1;
    check("bcount saturate", {32'd0, branchCount}, 64'hFFFF_FFFF);
    check("mcount after sat", {32'd0, mispredCount}, 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
